// File: rtl/ufm_cache_reader.sv
// Multi-line page cache in front of the ufm_streamer page engine: byte reads hit resident
// 16-byte pages, misses fill the round-robin victim, and an optional next-page prefetch.
module ufm_cache_reader #(
  parameter int ADDR_W    = 15,
  parameter int NUM_LINES = 2,
  parameter int PREFETCH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  output logic [7:0]        rsp_data_o,
  output logic              rsp_hit_o,
  input  logic              flush_i,
  output logic              strm_start_o,
  output logic [ADDR_W-5:0] strm_page_addr_o,
  input  logic              strm_ready_i,
  input  logic [7:0]        strm_data_i,
  input  logic              strm_stb_i
);

  localparam int PW = ADDR_W - 4;
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_ISSUE, S_FILL, S_RESP, S_PF_ISSUE, S_PF_FILL
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [PW-1:0]       tag_q [NUM_LINES];
  logic [LW-1:0]       repl_q;
  logic [LW-1:0]       victim_q;
  logic [3:0]          cnt_q;
  logic                fill_flushed_q;
  logic                rsp_valid_q;
  logic                rsp_hit_q;
  logic [7:0]          rsp_data_q;
  logic                strm_start_q;
  logic [PW-1:0]       strm_page_q;
  logic [7:0]          mem_q [NUM_LINES*16];

  logic [PW-1:0]       page;
  logic [PW-1:0]       page_inc;
  logic [3:0]          off;
  logic                hit;
  logic [LW-1:0]       hit_idx;
  logic                pf_resident;
  logic [LW-1:0]       repl_d;
  logic                fill_we;
  logic [7:0]          rd_data;

  assign page     = addr_q[ADDR_W-1:4];
  assign off      = addr_q[3:0];
  assign page_inc = page + 1'b1;
  assign repl_d   = (NUM_LINES == 1) ? '0 : repl_q + 1'b1;
  assign rd_data  = mem_q[{hit_idx, off}];
  assign fill_we  = !rst_i && strm_stb_i && (state_q == S_FILL || state_q == S_PF_FILL);

  // Lookups already honour a flush arriving this cycle.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    pf_resident = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && !flush_i) begin
        if (tag_q[i] == page) begin
          hit     = 1'b1;
          hit_idx = LW'(i);
        end
        if (tag_q[i] == page_inc) pf_resident = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) mem_q[{victim_q, cnt_q}] <= strm_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      valid_q        <= '0;
      repl_q         <= '0;
      victim_q       <= '0;
      cnt_q          <= '0;
      fill_flushed_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_hit_q      <= 1'b0;
      rsp_data_q     <= '0;
      strm_start_q   <= 1'b0;
      strm_page_q    <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
    end else begin
      rsp_valid_q  <= 1'b0;
      strm_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            rsp_data_q  <= rd_data;
            rsp_hit_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            victim_q        <= repl_q;
            valid_q[repl_q] <= 1'b0;
            strm_page_q     <= page;
            state_q         <= S_ISSUE;
          end
        end
        S_ISSUE, S_PF_ISSUE: begin
          if (strm_ready_i) begin
            strm_start_q   <= 1'b1;
            cnt_q          <= '0;
            fill_flushed_q <= 1'b0;
            state_q        <= (state_q == S_ISSUE) ? S_FILL : S_PF_FILL;
          end
        end
        S_FILL, S_PF_FILL: begin
          if (flush_i) fill_flushed_q <= 1'b1;
          if (strm_stb_i) begin
            cnt_q <= cnt_q + 4'd1;
            // Demand byte is captured as it streams past, so no read-after-write bypass is needed.
            if (state_q == S_FILL && cnt_q == off) rsp_data_q <= strm_data_i;
            if (cnt_q == 4'hF) begin
              tag_q[victim_q] <= strm_page_q;
              if (!fill_flushed_q && !flush_i) valid_q[victim_q] <= 1'b1;
              repl_q <= repl_d;
              if (state_q == S_FILL) begin
                rsp_valid_q <= 1'b1;
                rsp_hit_q   <= 1'b0;
                state_q     <= S_RESP;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_RESP: begin
          if (PREFETCH != 0 && NUM_LINES > 1 && !pf_resident) begin
            victim_q        <= repl_q;
            valid_q[repl_q] <= 1'b0;
            strm_page_q     <= page_inc;
            state_q         <= S_PF_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (flush_i) valid_q <= '0;
    end
  end

  assign req_ready_o      = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_hit_o        = rsp_hit_q;
  assign strm_start_o     = strm_start_q;
  assign strm_page_addr_o = strm_page_q;

endmodule

// File: tb/tb_ufm_cache_reader.sv
// Directed bench for ufm_cache_reader: a prefetching instance and a demand-only instance share
// one behavioural streamer; a select bit routes requests and strobes to one of them.
module tb_ufm_cache_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, flush_main, flush_strm, hold_rdy, strm_busy, strm_stb, sel;
  logic [14:0] req_addr;
  logic [7:0]  strm_data;
  logic        flush, strm_ready;

  logic        rdy0, rv0, rh0, ss0, rdy1, rv1, rh1, ss1;
  logic [7:0]  rd0, rd1;
  logic [10:0] sp0, sp1;
  logic        rdy_m, rv_m, rh_m, ss_m;
  logic [7:0]  rd_m;
  logic [10:0] sp_m;

  assign flush      = flush_main | flush_strm;
  assign strm_ready = !strm_busy && !hold_rdy;
  assign rdy_m = sel ? rdy1 : rdy0;
  assign rv_m  = sel ? rv1  : rv0;
  assign rh_m  = sel ? rh1  : rh0;
  assign ss_m  = sel ? ss1  : ss0;
  assign rd_m  = sel ? rd1  : rd0;
  assign sp_m  = sel ? sp1  : sp0;

  ufm_cache_reader #(.ADDR_W(15), .NUM_LINES(2), .PREFETCH(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid && !sel), .req_ready_o(rdy0), .req_addr_i(req_addr),
    .rsp_valid_o(rv0), .rsp_data_o(rd0), .rsp_hit_o(rh0), .flush_i(flush),
    .strm_start_o(ss0), .strm_page_addr_o(sp0), .strm_ready_i(strm_ready),
    .strm_data_i(strm_data), .strm_stb_i(strm_stb && !sel)
  );

  ufm_cache_reader #(.ADDR_W(15), .NUM_LINES(2), .PREFETCH(0)) u_dut_np (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid && sel), .req_ready_o(rdy1), .req_addr_i(req_addr),
    .rsp_valid_o(rv1), .rsp_data_o(rd1), .rsp_hit_o(rh1), .flush_i(flush),
    .strm_start_o(ss1), .strm_page_addr_o(sp1), .strm_ready_i(strm_ready),
    .strm_data_i(strm_data), .strm_stb_i(strm_stb && sel)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          start_cnt = 0;
  int          rsp_cnt = 0;
  int          flush_start = -1;
  logic [10:0] last_pg = '0;

  function automatic logic [7:0] page_byte(input logic [10:0] pg, input logic [3:0] k);
    return {pg[3:0] ^ 4'h2, k};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Streamer model: answers each strm_start with 16 strobes, optionally flushing on the last.
  initial begin
    strm_busy  = 1'b0;
    strm_stb   = 1'b0;
    strm_data  = '0;
    flush_strm = 1'b0;
    forever begin
      @(negedge clk);
      if (ss_m === 1'b1) begin
        last_pg   = sp_m;
        start_cnt++;
        strm_busy = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
          strm_stb   = 1'b1;
          strm_data  = page_byte(last_pg, k[3:0]);
          flush_strm = (k == 15) && (start_cnt == flush_start);
          @(negedge clk);
        end
        strm_stb   = 1'b0;
        flush_strm = 1'b0;
        strm_busy  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rv_m === 1'b1) rsp_cnt++;
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(rdy_m === 1'b1 && !strm_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle"}, 32'(rdy_m === 1'b1 && !strm_busy), 1);
  endtask

  task automatic do_req(input string nm, input logic [14:0] a, input logic eh,
                        input logic [7:0] ed, input logic epf, input logic [10:0] epg);
    int   s0, s1, lat;
    logic seen;
    wait_idle(nm);
    s0        = start_cnt;
    req_addr  = a;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rv_m !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    seen = (rv_m === 1'b1);
    chk({nm, " rsp_valid"}, 32'(seen), 1);
    chk({nm, " rsp_data"}, 32'(rd_m), 32'(ed));
    chk({nm, " rsp_hit"}, 32'(rh_m), 32'(eh));
    if (eh) chk({nm, " hit latency"}, 32'(lat), 2);
    chk({nm, " demand starts"}, 32'(start_cnt - s0), eh ? 0 : 1);
    if (!eh) chk({nm, " demand page"}, 32'(last_pg), 32'(a[14:4]));
    s1 = start_cnt;
    @(negedge clk);
    chk({nm, " rsp pulse width"}, 32'(rv_m), 0);
    wait_idle(nm);
    chk({nm, " prefetch starts"}, 32'(start_cnt - s1), epf ? 1 : 0);
    if (epf) chk({nm, " prefetch page"}, 32'(last_pg), 32'(epg));
  endtask

  typedef struct {
    logic        sel;
    logic [14:0] addr;
    logic        hit;
    logic [7:0]  data;
    logic        pf;
    logic [10:0] pf_pg;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n, rb;
    // sel, addr, hit, data, prefetch, prefetch page
    vecs[0]  = '{1'b0, 15'h0023, 1'b0, 8'h03, 1'b1, 11'h003};
    vecs[1]  = '{1'b0, 15'h002F, 1'b1, 8'h0F, 1'b0, 11'h000};
    vecs[2]  = '{1'b0, 15'h0035, 1'b1, 8'h15, 1'b1, 11'h004};
    vecs[3]  = '{1'b0, 15'h7FF5, 1'b0, 8'hD5, 1'b1, 11'h000};
    vecs[4]  = '{1'b0, 15'h0001, 1'b1, 8'h21, 1'b1, 11'h001};
    vecs[5]  = '{1'b0, 15'h0012, 1'b1, 8'h32, 1'b1, 11'h002};
    vecs[6]  = '{1'b1, 15'h0010, 1'b0, 8'h30, 1'b0, 11'h000};
    vecs[7]  = '{1'b1, 15'h0027, 1'b0, 8'h07, 1'b0, 11'h000};
    vecs[8]  = '{1'b1, 15'h0039, 1'b0, 8'h19, 1'b0, 11'h000};
    vecs[9]  = '{1'b1, 15'h002A, 1'b1, 8'h0A, 1'b0, 11'h000};
    vecs[10] = '{1'b1, 15'h001C, 1'b0, 8'h3C, 1'b0, 11'h000};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    flush_main = 1'b0;
    hold_rdy   = 1'b0;
    sel        = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(rdy0), 0);
    chk("reset rsp_valid", 32'(rv0), 0);
    chk("reset rsp_hit", 32'(rh0), 0);
    chk("reset rsp_data", 32'(rd0), 0);
    chk("reset strm_start", 32'(ss0), 0);
    chk("reset strm_page", 32'(sp0), 0);
    chk("reset req_ready np", 32'(rdy1), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release req_ready", 32'(rdy0), 1);

    for (int i = 0; i < 11; i++) begin
      sel = vecs[i].sel;
      do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hit, vecs[i].data,
             vecs[i].pf, vecs[i].pf_pg);
    end
    sel = 1'b0;

    // Flush on the 16th strobe: data still returned, line left invalid.
    flush_start = start_cnt + 1;
    do_req("flush16", 15'h0044, 1'b0, 8'h64, 1'b1, 11'h005);
    do_req("flush16 repeat", 15'h0044, 1'b0, 8'h64, 1'b0, 11'h000);

    // Streamer held busy: the miss must park in ISSUE.
    hold_rdy = 1'b1;
    wait_idle("hold");
    s0        = start_cnt;
    req_addr  = 15'h0080;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d no start", c), 32'(start_cnt - s0), 0);
      chk($sformatf("hold c%0d req_ready", c), 32'(rdy0), 0);
    end
    hold_rdy = 1'b0;
    n = 0;
    while (!strm_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold released start", 32'(strm_busy), 1);
    chk("hold released page", 32'(last_pg), 32'h008);

    // Reset in the middle of the fill.
    repeat (6) @(negedge clk);
    rb  = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midfill rst req_ready", 32'(rdy0), 0);
    chk("midfill rst strm_start", 32'(ss0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midfill release req_ready", 32'(rdy0), 1);
    n = 0;
    while (strm_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midfill stream drained", 32'(strm_busy), 0);
    chk("midfill no rsp", 32'(rsp_cnt - rb), 0);
    chk("midfill still ready", 32'(rdy0), 1);
    do_req("post rst p4", 15'h0044, 1'b0, 8'h64, 1'b1, 11'h005);
    do_req("post rst p5", 15'h0050, 1'b1, 8'h70, 1'b1, 11'h006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
